// File: rtl/exc_pkg.sv
// Shared definitions for the writeback exception sequencer:
// ExcCode values, bad-address source select and the sequencer state type.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [1:0] BADVA_NONE = 2'd0;
  localparam logic [1:0] BADVA_PC   = 2'd1;
  localparam logic [1:0] BADVA_MEM  = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder from writeback exception flags to ExcCode and
// the source of the bad virtual address.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       ifetch_err,
  input  logic       ri,
  input  logic       syscall,
  input  logic       brk,
  input  logic       ovf,
  input  logic       adel,
  input  logic       ades,
  input  logic       interrupt,
  output logic       hit,
  output logic [4:0] code,
  output logic [1:0] badva_sel
);

  always_comb begin
    hit       = 1'b1;
    code      = EXC_INT;
    badva_sel = BADVA_NONE;
    if (ifetch_err) begin
      code      = EXC_ADEL;
      badva_sel = BADVA_PC;
    end else if (ri) begin
      code = EXC_RI;
    end else if (syscall) begin
      code = EXC_SYS;
    end else if (brk) begin
      code = EXC_BP;
    end else if (ovf) begin
      code = EXC_OV;
    end else if (adel) begin
      code      = EXC_ADEL;
      badva_sel = BADVA_MEM;
    end else if (ades) begin
      code      = EXC_ADES;
      badva_sel = BADVA_MEM;
    end else if (interrupt) begin
      code = EXC_INT;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Writeback-stage exception/ERET sequencer: kills the faulting commit,
// reports the event to cp0, redirects fetch and flushes the pipeline.
//
//   state | meaning
//   IDLE  | watching WB for an exception or ERET
//   FLUSH | pipeline invalidated, counting down FLUSH_CYCLES
module exception_unit
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        WB_VALID,
  input  logic [31:0] WB_PC,
  input  logic        WB_BRANCH,
  input  logic [31:0] WB_MEM_ADDR,
  input  logic        WB_IFETCH_ERR,
  input  logic        WB_RI,
  input  logic        WB_SYSCALL,
  input  logic        WB_BREAK,
  input  logic        WB_OVF,
  input  logic        WB_ADEL,
  input  logic        WB_ADES,
  input  logic        WB_ERET,
  input  logic        INTERRUPT,
  input  logic [31:0] EPC_Q,
  output logic        WB_KILL,
  output logic        E_ENTER,
  output logic        ERET,
  output logic [31:0] EPC,
  output logic [4:0]  CAUSE,
  output logic [31:0] BAD_VA,
  output logic        DELAY_SLOT,
  output logic        FLUSH,
  output logic        PC_REDIRECT,
  output logic [31:0] PC_TARGET,
  output logic        BUSY
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bd_q;
  logic             hit;
  logic [4:0]       code;
  logic [1:0]       badva_sel;
  logic             idle, exc, ret;
  logic [31:0]      epc_d, badva_d;

  exc_prio_enc u_prio (
    .ifetch_err (WB_IFETCH_ERR),
    .ri         (WB_RI),
    .syscall    (WB_SYSCALL),
    .brk        (WB_BREAK),
    .ovf        (WB_OVF),
    .adel       (WB_ADEL),
    .ades       (WB_ADES),
    .interrupt  (INTERRUPT),
    .hit        (hit),
    .code       (code),
    .badva_sel  (badva_sel)
  );

  // Interrupts are only taken against a real instruction so EPC is meaningful.
  assign idle    = (state_q == IDLE);
  assign exc     = idle & WB_VALID & hit;
  assign ret     = idle & WB_VALID & WB_ERET & ~hit;
  assign WB_KILL = ~idle | exc;
  assign FLUSH   = ~idle;
  assign BUSY    = ~idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (exc | ret) begin
          state_d = exc_pkg::FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      exc_pkg::FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // bd_q remembers whether the last committed instruction was a branch.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bd_q <= 1'b0;
    end else if (idle) begin
      if (exc | ret)     bd_q <= 1'b0;
      else if (WB_VALID) bd_q <= WB_BRANCH;
    end
  end

  always_comb begin
    epc_d = bd_q ? (WB_PC - 32'd4) : WB_PC;
    case (badva_sel)
      BADVA_PC:  badva_d = WB_PC;
      BADVA_MEM: badva_d = WB_MEM_ADDR;
      default:   badva_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      E_ENTER     <= 1'b0;
      ERET        <= 1'b0;
      EPC         <= '0;
      CAUSE       <= '0;
      BAD_VA      <= '0;
      DELAY_SLOT  <= 1'b0;
      PC_REDIRECT <= 1'b0;
      PC_TARGET   <= '0;
    end else begin
      E_ENTER     <= exc;
      ERET        <= ret;
      EPC         <= exc ? epc_d : '0;
      CAUSE       <= exc ? code : '0;
      BAD_VA      <= exc ? badva_d : '0;
      DELAY_SLOT  <= exc & bd_q;
      PC_REDIRECT <= exc | ret;
      PC_TARGET   <= exc ? EXC_VECTOR : (ret ? EPC_Q : '0);
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: vector table plus hand sequences,
// registered outputs checked through an expectation queue one cycle later.
module tb_exception_unit;

  localparam int FC = 2;
  localparam logic [7:0] F_IF = 8'h80, F_RI = 8'h40, F_SYS = 8'h20, F_BRK = 8'h10;
  localparam logic [7:0] F_OVF = 8'h08, F_ADEL = 8'h04, F_ADES = 8'h02, F_ERET = 8'h01;

  logic clk = 1'b0;
  logic rst_n;
  logic wb_valid, wb_branch, wb_ifetch_err, wb_ri, wb_syscall, wb_break;
  logic wb_ovf, wb_adel, wb_ades, wb_eret, interrupt;
  logic [31:0] wb_pc, wb_mem_addr, epc_q;
  logic wb_kill, e_enter, eret, delay_slot, flush, pc_redirect, busy;
  logic [31:0] epc, bad_va, pc_target;
  logic [4:0] cause;

  always #5 clk = ~clk;

  exception_unit #(.EXC_VECTOR(32'h0000_0100), .FLUSH_CYCLES(FC)) dut (
    .CLK(clk), .RESET_N(rst_n), .WB_VALID(wb_valid), .WB_PC(wb_pc),
    .WB_BRANCH(wb_branch), .WB_MEM_ADDR(wb_mem_addr), .WB_IFETCH_ERR(wb_ifetch_err),
    .WB_RI(wb_ri), .WB_SYSCALL(wb_syscall), .WB_BREAK(wb_break), .WB_OVF(wb_ovf),
    .WB_ADEL(wb_adel), .WB_ADES(wb_ades), .WB_ERET(wb_eret), .INTERRUPT(interrupt),
    .EPC_Q(epc_q), .WB_KILL(wb_kill), .E_ENTER(e_enter), .ERET(eret), .EPC(epc),
    .CAUSE(cause), .BAD_VA(bad_va), .DELAY_SLOT(delay_slot), .FLUSH(flush),
    .PC_REDIRECT(pc_redirect), .PC_TARGET(pc_target), .BUSY(busy)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        branch;
    logic [31:0] maddr;
    logic [7:0]  fl;
    logic        intr;
    logic [31:0] epcq;
  } in_t;

  typedef struct {
    logic        e_enter;
    logic        eret;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [31:0] badva;
    logic        ds;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic        busy;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    logic  kill;
    exp_t  nxt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic in_t mk(logic v, logic [31:0] pc, logic br, logic [31:0] ma,
                             logic [7:0] fl, logic intr, logic [31:0] eq);
    in_t r;
    r.valid = v; r.pc = pc; r.branch = br; r.maddr = ma;
    r.fl = fl; r.intr = intr; r.epcq = eq;
    return r;
  endfunction

  function automatic exp_t e_idle();
    exp_t r;
    r.e_enter = 0; r.eret = 0; r.epc = 0; r.cause = 0; r.badva = 0;
    r.ds = 0; r.flush = 0; r.redir = 0; r.target = 0; r.busy = 0;
    return r;
  endfunction

  function automatic exp_t e_flush();
    exp_t r = e_idle();
    r.flush = 1; r.busy = 1;
    return r;
  endfunction

  function automatic exp_t e_entry(logic [4:0] c, logic [31:0] pc, logic [31:0] bva, logic ds);
    exp_t r = e_flush();
    r.e_enter = 1; r.redir = 1; r.target = 32'h0000_0100;
    r.cause = c; r.epc = pc; r.badva = bva; r.ds = ds;
    return r;
  endfunction

  function automatic exp_t e_ret(logic [31:0] t);
    exp_t r = e_flush();
    r.eret = 1; r.redir = 1; r.target = t;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic compare(input string nm, input exp_t e);
    chk({nm, ".e_enter"},  32'(e_enter),     32'(e.e_enter));
    chk({nm, ".eret"},     32'(eret),        32'(e.eret));
    chk({nm, ".epc"},      epc,              e.epc);
    chk({nm, ".cause"},    32'(cause),       32'(e.cause));
    chk({nm, ".bad_va"},   bad_va,           e.badva);
    chk({nm, ".ds"},       32'(delay_slot),  32'(e.ds));
    chk({nm, ".flush"},    32'(flush),       32'(e.flush));
    chk({nm, ".redirect"}, 32'(pc_redirect), 32'(e.redir));
    chk({nm, ".target"},   pc_target,        e.target);
    chk({nm, ".busy"},     32'(busy),        32'(e.busy));
  endtask

  task automatic apply(input in_t i);
    wb_valid = i.valid; wb_pc = i.pc; wb_branch = i.branch; wb_mem_addr = i.maddr;
    {wb_ifetch_err, wb_ri, wb_syscall, wb_break, wb_ovf, wb_adel, wb_ades, wb_eret} = i.fl;
    interrupt = i.intr; epc_q = i.epcq;
  endtask

  // One clock: drive, check WB_KILL and this cycle's predicted outputs, queue next.
  task automatic cyc(input string nm, input in_t i, input logic kill, input exp_t nxt);
    exp_t e;
    apply(i);
    @(negedge clk);
    chk({nm, ".kill"}, 32'(wb_kill), 32'(kill));
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard actual=empty required=entry", nm);
    end else begin
      e = sb.pop_front();
      compare(nm, e);
    end
    sb.push_back(nxt);
    @(posedge clk); #1;
  endtask

  // Flush window with hostile inputs that must all be ignored.
  task automatic flush_seq(input string nm);
    in_t noise = mk(1, 32'hDEAD_0000, 1, 32'h1234, F_SYS | F_ERET | F_IF, 1, 32'h55);
    for (int k = 1; k <= FC; k++) begin
      if (k < FC) cyc({nm, ".fl"}, noise, 1'b1, e_flush());
      else        cyc({nm, ".fl"}, noise, 1'b1, e_idle());
    end
  endtask

  task automatic add(input string nm, input in_t i, input logic k, input exp_t n);
    vec_t v;
    v.name = nm; v.in = i; v.kill = k; v.nxt = n;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    add("sys",      mk(1, 32'h40, 0, 0, F_SYS, 0, 0),          1, e_entry(8, 32'h40, 0, 0));
    add("ades",     mk(1, 32'h80, 0, 32'h1003, F_ADES, 0, 0),  1, e_entry(5, 32'h80, 32'h1003, 0));
    add("ifetch",   mk(1, 32'h7, 0, 32'h99, F_IF, 0, 0),       1, e_entry(4, 32'h7, 32'h7, 0));
    add("adel",     mk(1, 32'h44, 0, 32'h2001, F_ADEL, 0, 0),  1, e_entry(4, 32'h44, 32'h2001, 0));
    add("brk",      mk(1, 32'h48, 0, 0, F_BRK, 0, 0),          1, e_entry(9, 32'h48, 0, 0));
    add("ovf",      mk(1, 32'h4C, 0, 0, F_OVF, 0, 0),          1, e_entry(12, 32'h4C, 0, 0));
    add("int",      mk(1, 32'h50, 0, 0, 8'h00, 1, 0),          1, e_entry(0, 32'h50, 0, 0));
    add("bubble",   mk(0, 32'h54, 0, 0, F_SYS, 1, 0),          0, e_idle());
    add("eret",     mk(1, 32'h60, 0, 0, F_ERET, 0, 32'h3C),    0, e_ret(32'h3C));
    add("eret_sys", mk(1, 32'h64, 0, 0, F_ERET | F_SYS, 0, 32'h3C), 1, e_entry(8, 32'h64, 0, 0));
    add("ovf_ades", mk(1, 32'h68, 0, 32'h77, F_OVF | F_ADES, 0, 0), 1, e_entry(12, 32'h68, 0, 0));

    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    #8;
    chk("reset.kill", 32'(wb_kill), 32'd0);
    compare("reset", e_idle());
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(e_idle());

    foreach (tbl[n]) begin
      cyc(tbl[n].name, tbl[n].in, tbl[n].kill, tbl[n].nxt);
      if (tbl[n].nxt.flush) flush_seq(tbl[n].name);
    end

    // Delay-slot tracking, held across a bubble; EPC wrap below zero.
    cyc("br_commit", mk(1, 32'h200, 1, 0, 0, 0, 0), 0, e_idle());
    cyc("br_bubble", mk(0, 32'h0, 0, 0, 0, 0, 0), 0, e_idle());
    cyc("ds_ovf", mk(1, 32'h204, 0, 0, F_OVF, 0, 0), 1, e_entry(12, 32'h200, 0, 1));
    flush_seq("ds_ovf");
    cyc("br0", mk(1, 32'h0, 1, 0, 0, 0, 0), 0, e_idle());
    cyc("wrap_int", mk(1, 32'h0, 0, 0, 0, 1, 0), 1, e_entry(0, 32'hFFFF_FFFC, 0, 1));
    flush_seq("wrap_int");
    cyc("br_c2", mk(1, 32'h300, 1, 0, 0, 0, 0), 0, e_idle());
    cyc("nb_commit", mk(1, 32'h304, 0, 0, 0, 0, 0), 0, e_idle());
    cyc("sys_after", mk(1, 32'h308, 0, 0, F_SYS, 0, 0), 1, e_entry(8, 32'h308, 0, 0));
    flush_seq("sys_after");

    // Pending interrupt waits through flush and a bubble.
    cyc("int_ri_ovf", mk(1, 32'h400, 0, 0, F_RI | F_OVF, 1, 0), 1, e_entry(10, 32'h400, 0, 0));
    flush_seq("int_ri_ovf");
    cyc("int_bubble", mk(0, 32'h404, 0, 0, 0, 1, 0), 0, e_idle());
    cyc("int_take", mk(1, 32'h408, 0, 0, 0, 1, 0), 1, e_entry(0, 32'h408, 0, 0));
    flush_seq("int_take");

    // Reset in the cycle after entry.
    cyc("rb_commit", mk(1, 32'h600, 1, 0, 0, 0, 0), 0, e_idle());
    cyc("rst_sys", mk(1, 32'h604, 0, 0, F_SYS, 0, 0), 1, e_entry(8, 32'h600, 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst_pre.e_enter", 32'(e_enter), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async.kill", 32'(wb_kill), 32'd0);
    compare("rst_async", e_idle());
    sb.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(e_idle());
    cyc("rst_brk", mk(1, 32'h700, 0, 0, F_BRK, 0, 0), 1, e_entry(9, 32'h700, 0, 0));
    flush_seq("rst_brk");

    // Reset clears a remembered branch.
    cyc("rb2", mk(1, 32'h800, 1, 0, 0, 0, 0), 0, e_idle());
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc("rst_bd_brk", mk(1, 32'h804, 0, 0, F_BRK, 0, 0), 1, e_entry(9, 32'h804, 0, 0));
    flush_seq("rst_bd_brk");
    cyc("tail", mk(0, 0, 0, 0, 0, 0, 0), 0, e_idle());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
